// File: rtl/data_memory_mmio.sv
// Byte-addressed little-endian data RAM with MMIO input/ADC snapshots and IRQ mask/status.
// DMEM_CHANGE_IRQ_EN enables change-detect pending bits and the irq output.
module data_memory_mmio #(
  parameter int ADDR_W        = 10,
  parameter int WORD_BYTES    = 3,
  parameter int NUM_ADC       = 3,
  parameter int ADC_W         = 8,
  parameter int IRQ_MASK_ADDR = 985,
  parameter int IRQ_STAT_ADDR = 986,
  localparam int DW           = 8 * WORD_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        readAddr,
  input  logic [ADDR_W-1:0]        writeAddr,
  input  logic                     WE,
  input  logic [DW-1:0]            writeData,
  input  logic [DW-1:0]            inputPort,
  input  logic [NUM_ADC*ADC_W-1:0] adcIn,
  output logic [DW-1:0]            readData,
  output logic [7:0]               irqMask,
  output logic                     irq
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int NW        = NUM_ADC + 1;
  localparam int MMIO_BASE = DEPTH - WORD_BYTES * NW;
  localparam int AW1       = ADDR_W + 1;

  localparam logic [AW1-1:0] DEPTH_A = AW1'(DEPTH);
  localparam logic [AW1-1:0] MMIO_A  = AW1'(MMIO_BASE);
  localparam logic [AW1-1:0] MASK_A  = AW1'(IRQ_MASK_ADDR);
  localparam logic [AW1-1:0] STAT_A  = AW1'(IRQ_STAT_ADDR);

`ifdef DMEM_CHANGE_IRQ_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic [7:0]               mem_q [DEPTH];
  logic [DW-1:0]            in_snap_q;
  logic [NUM_ADC*ADC_W-1:0] adc_snap_q;
  logic [7:0]               mask_q;
  logic [7:0]               pend_q;
  logic [DW-1:0]            rdata_q;
  logic [DW-1:0]            rdata_d;
  logic [8*WORD_BYTES*NW-1:0] img;
  logic [WORD_BYTES-1:0]    wr_mem;
  logic [WORD_BYTES-1:0]    wr_mask;
  logic [AW1-1:0]           wr_a [WORD_BYTES];
  logic [AW1-1:0]           ra;
  logic [7:0]               rb;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_snap_q  <= '0;
      adc_snap_q <= '0;
    end else begin
      in_snap_q  <= inputPort;
      adc_snap_q <= adcIn;
    end
  end

  // MMIO image, lowest word (ADC NUM_ADC-1) at MMIO_BASE
  always_comb begin
    img = '0;
    img[DW*NUM_ADC +: DW] = in_snap_q;
    for (int k = 0; k < NUM_ADC; k++)
      img[DW*(NUM_ADC-1-k) +: DW] = DW'(adc_snap_q[k*ADC_W +: ADC_W]);
  end

  always_comb begin
    wr_mem  = '0;
    wr_mask = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      wr_a[i] = {1'b0, writeAddr} + AW1'(i);
      if (WE && !rst && wr_a[i] < MMIO_A) begin
        if (wr_a[i] == MASK_A)
          wr_mask[i] = 1'b1;
        else if (!(CHG_EN && wr_a[i] == STAT_A))
          wr_mem[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++)
      if (wr_mem[i])
        mem_q[wr_a[i][ADDR_W-1:0]] <= writeData[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (wr_mask[i])
          mask_q <= writeData[8*i +: 8];
    end
  end

  always_comb begin
    rdata_d = '0;
    ra      = '0;
    rb      = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      ra = {1'b0, readAddr} + AW1'(i);
      rb = '0;
      if (ra < DEPTH_A) begin
        if (CHG_EN && ra == STAT_A)
          rb = pend_q;
        else if (ra == MASK_A)
          rb = mask_q;
        else if (ra >= MMIO_A)
          rb = img[8*int'(ra - MMIO_A) +: 8];
        else
          rb = mem_q[ra[ADDR_W-1:0]];
      end
      rdata_d[8*i +: 8] = rb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else
      rdata_q <= rdata_d;
  end

`ifdef DMEM_CHANGE_IRQ_EN
  localparam logic [7:0] PEND_VALID = 8'((1 << NW) - 1);

  logic                     arm_q;
  logic [DW-1:0]            in_prev_q;
  logic [NUM_ADC*ADC_W-1:0] adc_prev_q;
  logic [7:0]               set;
  logic [7:0]               clr;

  always_comb begin
    clr = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      if (WE && !rst && wr_a[i] == STAT_A && wr_a[i] < MMIO_A)
        clr = clr | writeData[8*i +: 8];
  end

  always_comb begin
    set    = '0;
    set[0] = (in_snap_q != in_prev_q);
    for (int k = 0; k < NUM_ADC; k++)
      set[k+1] = (adc_snap_q[k*ADC_W +: ADC_W] != adc_prev_q[k*ADC_W +: ADC_W]);
    if (!arm_q)
      set = '0;
    set = set & PEND_VALID;
  end

  // Arming cycle loads the baseline from the fresh snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q      <= 1'b0;
      in_prev_q  <= '0;
      adc_prev_q <= '0;
      pend_q     <= '0;
    end else begin
      arm_q      <= 1'b1;
      in_prev_q  <= arm_q ? in_snap_q : inputPort;
      adc_prev_q <= arm_q ? adc_snap_q : adcIn;
      pend_q     <= ((pend_q & ~clr) | set) & PEND_VALID;
    end
  end

  assign irq = |(pend_q & mask_q);
`else
  assign pend_q = '0;
  assign irq    = 1'b0;
`endif

  assign readData = rdata_q;
  assign irqMask  = mask_q;

endmodule

// File: doc/data_memory_mmio.md
# data_memory_mmio

Parametrised successor of the unified data memory: a byte-addressed, little-endian RAM holding multi-byte words, with a memory-mapped input port and a configurable number of ADC channels at the top of the address space. It also provides a byte-wide interrupt mask register and optional change-detect interrupts. It sits between the core's memory stage (read and write ports) and the board I/O (input port, ADC samplers), and it drives the interrupt request into the core.

## Interface
Parameters:
- ADDR_W, 10, byte-address width; DEPTH = 2^ADDR_W bytes.
- WORD_BYTES, 3, bytes per read or write word; DW = 8*WORD_BYTES.
- NUM_ADC, 3, ADC channel count, 0..7.
- ADC_W, 8, ADC sample width, 1..DW.
- IRQ_MASK_ADDR, 985, byte address of the interrupt mask byte.
- IRQ_STAT_ADDR, 986, byte address of the interrupt pending/status byte.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- readAddr  in  ADDR_W  byte address of read word (low byte).
- writeAddr  in  ADDR_W  byte address of write word (low byte).
- WE  in  1  write enable.
- writeData  in  DW  write word, byte 0 at writeAddr.
- inputPort  in  DW  external input port.
- adcIn  in  NUM_ADC*ADC_W  ADC samples; channel k at bits [k*ADC_W +: ADC_W].
- readData  out  DW  registered read word.
- irqMask  out  8  current interrupt mask byte.
- irq  out  1  interrupt request, level.

## Operation
- Address map:
  - MMIO_BASE = DEPTH − WORD_BYTES*(NUM_ADC+1).
  - The input port occupies the top WORD_BYTES bytes, at DEPTH−WORD_BYTES.
  - ADC k occupies the word at DEPTH − WORD_BYTES*(k+2). Its sample sits in the low bits, zero-extended to DW.
  - Bytes below MMIO_BASE are RAM.
- MMIO snapshot: inputPort and all adcIn channels are registered into snapshot registers every cycle. Reads of MMIO bytes return the snapshot bytes.
- Read: every cycle, readData <= bytes [readAddr .. readAddr+WORD_BYTES−1], little-endian.
  - Bytes at addresses ≥ DEPTH read as 0; there is no wrap-around.
  - Reading IRQ_STAT_ADDR returns the pending byte.
- Write: when WE=1, each byte writeAddr+i (i < WORD_BYTES) is written if its address is < MMIO_BASE. Bytes at or above MMIO_BASE, or ≥ DEPTH, are silently dropped; the other bytes of the word are still written.
- Mask register: the byte at IRQ_MASK_ADDR is ordinary RAM, continuously exported on irqMask.
- Status byte: a write byte landing on IRQ_STAT_ADDR does not store into RAM. It applies write-1-to-clear to the pending bits.
- Read-during-write to the same byte in the same cycle returns the old value (read-first).
- Reset:
  - readData = 0.
  - Snapshots = 0.
  - Mask byte = 0, so irqMask = 0.
  - Pending = 0; irq = 0.
  - The change-detect arm flag is cleared.
  - Other RAM bytes are not cleared by rst; they are zero at configuration.
- WE during rst is ignored.

## Timing
- Read latency: 1 cycle. readAddr at edge N gives readData valid after edge N+1.
- Write visible to a read issued on the following cycle.
- Input-to-readData latency: 2 cycles (snapshot, then read register).
- irqMask updates on the edge that writes it. irq is a combinational AND/OR of pending and mask, so it follows the same edge.
- Pending bit set: 1 cycle after a snapshot change, i.e. 2 cycles after the input changes.
- Simultaneous set and W1C clear of the same pending bit: set wins.
- Reset mid-operation: all registered outputs return to their reset values on that edge. The cycle after reset deassertion only arms change detect and never sets a pending bit.

## Configuration
- Macro: DMEM_CHANGE_IRQ_EN.
- Defined:
  - Pending bit 0 is set when the input-port snapshot differs from its previous value.
  - Pending bit k+1 is set when the ADC k snapshot changes.
  - Bits above NUM_ADC+1 read 0.
  - irq = |(pending & irqMask).
- Undefined:
  - No change-detect logic.
  - Pending reads 0 and irq is tied 0.
  - A write byte landing on IRQ_STAT_ADDR is stored as ordinary RAM.
  - The mask byte is still stored and exported.

## Test plan
- Write 0xA1B2C3 to address 0x010, then read 0x010 and 0x011 on consecutive cycles -> readData=0xA1B2C3, then 0x00A1B2 (byte 0x013 zero).
- Write 0x112233 to MMIO_BASE−1 (1011 at defaults) -> byte 1011 = 0x33; MMIO bytes unchanged; a read at 1011 returns 0x000033 plus the snapshot bytes above.
- inputPort=0x00CAFE held, adcIn ch1=0x5A -> read 1021 gives 0x00CAFE; read 1015 gives 0x00005A, both within 2 cycles.
- Reset, then write mask 0x01 at 985; toggle inputPort -> irq rises 2 cycles later; write 0x01 to 986 -> irq falls next edge; read 986 -> 0x00.
- Change on the same edge as the W1C write -> pending bit stays 1 and irq stays 1.
- Assert rst with pending=0x03 and mask=0xFF -> after the edge, irq=0, irqMask=0, readData=0; no spurious pending bit on the first post-reset cycle.
